// File: rtl/maze_gfx_pkg.sv
// maze_gfx_pkg: shared maze graphics constants, FSM states and colour type
package maze_gfx_pkg;
   localparam logic [8:0] X_OFFSET   = 9'd80;
   localparam logic [8:0] CELL_PITCH = 9'd10;
   localparam logic [3:0] BOX_SIZE   = 4'd9;
   localparam logic [4:0] MAX_CELL   = 5'd23;
   localparam logic [8:0] SCREEN_W   = 9'd320;
   localparam logic [8:0] SCREEN_H   = 9'd240;
   typedef enum logic [1:0] {IDLE, DRAW, FINISH} state_t;
   typedef logic [2:0] colour_t;
endpackage

// File: rtl/box_scan_counter.sv
// box_scan_counter: raster cx/cy counter over a BOX_SIZE x BOX_SIZE box
module box_scan_counter
   import maze_gfx_pkg::*;
(
   input  logic       clk,
   input  logic       reset,
   input  logic       clear,
   input  logic       advance,
   output logic [3:0] cx,
   output logic [3:0] cy,
   output logic       last
);
   assign last = cx == BOX_SIZE - 4'd1 && cy == BOX_SIZE - 4'd1;
   // step x every advance, wrap into the next row at the box edge
   always_ff @(posedge clk) begin
      if (reset || clear) begin
         cx <= 4'd0;
         cy <= 4'd0;
      end else if (advance) begin
         cx <= cx == BOX_SIZE - 4'd1 ? 4'd0 : cx + 4'd1;
         cy <= cx == BOX_SIZE - 4'd1 ? (cy == BOX_SIZE - 4'd1 ? 4'd0 : cy + 4'd1) : cy;
      end
   end
endmodule

// File: rtl/draw_new_box.sv
// draw_new_box: paints the 9x9 player box at a maze cell, one pixel per clock (DRAW_BORDER_EN inverts the edge colour)
module draw_new_box
   import maze_gfx_pkg::*;
(
   input  logic       clk,
   input  logic       reset,
   input  logic       start,
   input  logic [4:0] x_in,
   input  logic [4:0] y_in,
   input  logic [2:0] colour_in,
   output logic [8:0] x_loc,
   output logic [8:0] y_loc,
   output logic [2:0] colour,
   output logic       plot,
   output logic       busy,
   output logic       done,
   output logic       err
);
   state_t     state, state_n;
   logic [4:0] xl, yl, xs, ys;
   colour_t    cl, cs, pc;
   logic [3:0] cx, cy;
   logic [8:0] px, py;
   logic       last, last_q, accept, reject, drawing;

   // the counter runs one pixel ahead of the registered outputs
   box_scan_counter u_scan (
      .clk    (clk),
      .reset  (reset),
      .clear  (state == IDLE && !accept),
      .advance(drawing),
      .cx     (cx),
      .cy     (cy),
      .last   (last)
   );

   // next state and the pixel to present on the following cycle
   always_comb begin
      accept  = state == IDLE && start && x_in <= MAX_CELL && y_in <= MAX_CELL;
      reject  = state == IDLE && start && !accept;
      state_n = state == IDLE ? (accept ? DRAW : reject ? FINISH : IDLE)
              : state == DRAW ? (last_q ? FINISH : DRAW) : IDLE;
      drawing = state_n == DRAW;
      xs      = accept ? x_in : xl;
      ys      = accept ? y_in : yl;
      cs      = accept ? colour_in : cl;
      px      = X_OFFSET + CELL_PITCH * {4'd0, xs} + {5'd0, cx};
      py      = CELL_PITCH * {4'd0, ys} + {5'd0, cy};
`ifdef DRAW_BORDER_EN
      pc      = (cx == 4'd0 || cx == BOX_SIZE - 4'd1 || cy == 4'd0 || cy == BOX_SIZE - 4'd1) ? ~cs : cs;
`else
      pc      = cs;
`endif
   end

   // state register
   always_ff @(posedge clk) begin
      state <= reset ? IDLE : state_n;
   end

   // latched request and registered write-port outputs
   always_ff @(posedge clk) begin
      if (reset) begin
         {xl, yl, cl} <= '0;
         {x_loc, y_loc, colour} <= '0;
         {plot, busy, done, err, last_q} <= '0;
      end else begin
         if (accept) {xl, yl, cl} <= {x_in, y_in, colour_in};
         x_loc  <= drawing ? px : 9'd0;
         y_loc  <= drawing ? py : 9'd0;
         colour <= drawing ? pc : 3'd0;
         plot   <= drawing;
         busy   <= drawing;
         done   <= state_n == FINISH;
         err    <= reject;
         last_q <= drawing && last;
      end
   end
endmodule

// File: tb/tb_draw_new_box.sv
// tb_draw_new_box: randomized self-checking bench for draw_new_box against a per-pixel raster model
module tb_draw_new_box;
   logic       clk = 0, reset = 1, start = 0;
   logic [4:0] x_in = 0, y_in = 0;
   logic [2:0] colour_in = 0, colour;
   logic [8:0] x_loc, y_loc;
   logic       plot, busy, done, err;
   int         n_cmp = 0, n_bad = 0;

   draw_new_box dut (
      .clk(clk), .reset(reset), .start(start), .x_in(x_in), .y_in(y_in),
      .colour_in(colour_in), .x_loc(x_loc), .y_loc(y_loc), .colour(colour),
      .plot(plot), .busy(busy), .done(done), .err(err)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input int obs, input int exp);
      n_cmp++;
      if (obs != exp) begin
         n_bad++;
         $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
      end
   endtask

   task automatic idle_zero(input string tag);
      chk({tag, "_x"}, x_loc, 0);
      chk({tag, "_y"}, y_loc, 0);
      chk({tag, "_col"}, colour, 0);
      chk({tag, "_plot"}, plot, 0);
      chk({tag, "_busy"}, busy, 0);
      chk({tag, "_done"}, done, 0);
      chk({tag, "_err"}, err, 0);
   endtask

   // pixel k of the box: column k%9, row k/9; edges optionally inverted
   task automatic draw(input int x, input int y, input int c, input int poke, input int cut);
      int ec;
      @(negedge clk);
      start = 1; x_in = 5'(x); y_in = 5'(y); colour_in = 3'(c);
      @(negedge clk);
      start = 0; x_in = 5'($urandom); y_in = 5'($urandom); colour_in = 3'($urandom);
      for (int k = 0; k < 81; k++) begin
         ec = c;
`ifdef DRAW_BORDER_EN
         if (k % 9 == 0 || k % 9 == 8 || k / 9 == 0 || k / 9 == 8) ec = ~c & 7;
`endif
         chk("plot", plot, 1);
         chk("x_loc", x_loc, 80 + 10 * x + k % 9);
         chk("y_loc", y_loc, 10 * y + k / 9);
         chk("colour", colour, ec);
         chk("busy", busy, 1);
         chk("done_early", done, 0);
         if (k == cut) begin
            reset = 1;
            @(negedge clk);
            reset = 0;
            chk("cut_plot", plot, 0);
            chk("cut_busy", busy, 0);
            return;
         end
         start = (k == poke);
         @(negedge clk);
      end
      start = (poke >= 0);
      chk("done", done, 1);
      chk("err_on_done", err, 0);
      chk("end_plot", plot, 0);
      chk("end_busy", busy, 0);
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         start = 0;
         chk("after_plot", plot, 0);
         chk("after_done", done, 0);
      end
   endtask

   task automatic reject(input int x, input int y);
      @(negedge clk);
      start = 1; x_in = 5'(x); y_in = 5'(y); colour_in = 3'($urandom);
      @(negedge clk);
      start = 0;
      chk("rej_done", done, 1);
      chk("rej_err", err, 1);
      chk("rej_plot", plot, 0);
      chk("rej_busy", busy, 0);
      @(negedge clk);
      chk("rej_done_clr", done, 0);
      chk("rej_err_clr", err, 0);
   endtask

   initial begin
      int seen;
      repeat (3) @(negedge clk);
      reset = 0;
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         idle_zero("reset");
      end
      draw(0, 0, 3'b100, -1, -1);
      draw(23, 23, 3'b010, -1, -1);
      reject(24, 5);
      draw($urandom_range(0, 23), $urandom_range(0, 23), 3'b001, 20, -1);
      draw($urandom_range(0, 23), $urandom_range(0, 23), $urandom_range(0, 7), -1, 39);
      seen = 0;
      for (int i = 0; i < 100; i++) begin
         @(negedge clk);
         seen += int'(done) + int'(plot);
      end
      chk("no_done_after_cut", seen, 0);
      draw($urandom_range(0, 23), $urandom_range(0, 23), $urandom_range(0, 7), -1, -1);
      reject(3, 31);
      for (int i = 0; i < 6; i++) begin
         draw($urandom_range(0, 23), $urandom_range(0, 23), $urandom_range(0, 7), $urandom_range(0, 85) < 60 ? $urandom_range(0, 79) : -1, -1);
         if (i % 2 == 0) reject($urandom_range(24, 31), $urandom_range(0, 31));
         else reject($urandom_range(0, 31), $urandom_range(24, 31));
      end
      @(negedge clk);
      reset = 1; start = 1; x_in = 5'd3; y_in = 5'd3;
      @(negedge clk);
      reset = 0; start = 0;
      chk("rst_start_busy", busy, 0);
      chk("rst_start_plot", plot, 0);
      @(negedge clk);
      idle_zero("rst_start");
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule
